// File: rtl/decode_and_operand_fetch_pkg.sv
// Shared definitions for the decode/operand-fetch stage and its neighbours.
// Holds the opcode constants, the instruction field layout and the helper
// that maps an opcode onto its operand class (which slots it reads and
// whether it writes rd).
package decode_and_operand_fetch_pkg;

    localparam int DATA_W  = 16;
    localparam int REG_CNT = 16;
    localparam int ADDR_W  = 8;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_UNARY = 4'd9;
    localparam logic [3:0] OP_LOAD  = 4'd14;
    localparam logic [3:0] OP_STORE = 4'd15;

    // instr[15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2 ([7:0] doubles as memAddr)
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_t;

    typedef struct packed {
        logic rd1;   // reads source slot 1 (rs1, or rd for STORE)
        logic rd2;   // reads source slot 2 (rs2)
        logic wr;    // writes rd
    } op_class_t;

    function automatic op_class_t classify(input logic [3:0] op);
        op_class_t c;
        c.rd1 = (op != OP_NOP) && (op != OP_LOAD);
        c.rd2 = (op != OP_NOP) && (op != OP_UNARY) && (op != OP_LOAD) && (op != OP_STORE);
        c.wr  = (op != OP_NOP) && (op != OP_STORE);
        return c;
    endfunction

endpackage

// File: rtl/decode_and_operand_fetch_register_file.sv
// Architectural register file: REG_CNT x DATA_W, two asynchronous read
// ports, one synchronous write port, asynchronous active-low clear.
// Ports:
//   clk, rst        clock, async active-low clear of every register
//   raddr1/rdata1   read port 1 (combinational)
//   raddr2/rdata2   read port 2 (combinational)
//   we/waddr/wdata  write port, committed on the rising edge
module register_file #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 16,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [IDX_W-1:0]  raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [REG_CNT-1:0][DATA_W-1:0] regs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    regs <= '0;
        else if (we) regs[waddr] <= wdata;
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/decode_and_operand_fetch.sv
// Decode / operand-fetch stage: splits the fetched word into fields, reads
// operands (with write-back bypass), tracks pending writers in a busy-bit
// scoreboard, stalls on RAW/WAW hazards and issues one registered operation
// per cycle to the execute/store-back stage.
// Ports:
//   clk, rst                      clock, async active-low reset
//   instr, instr_valid            instruction word from fetch
//   instr_ready                   stage accepts instr this cycle
//   opcode, destReg, memAddr      issued operation (opcode 0 = bubble)
//   srcVal1/2, used1/2            operand values and live-operand flags
//   destRegStore, destVal,        write-back request from execute
//   storeNow
//   storeDone                     write-back committed (1-cycle pulse)
module decode_and_operand_fetch
    import decode_and_operand_fetch_pkg::*;
#(
    parameter int DATA_W  = decode_and_operand_fetch_pkg::DATA_W,
    parameter int REG_CNT = decode_and_operand_fetch_pkg::REG_CNT,
    parameter int ADDR_W  = decode_and_operand_fetch_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [3:0]        opcode,
    output logic [3:0]        destReg,
    output logic [DATA_W-1:0] srcVal1,
    output logic [DATA_W-1:0] srcVal2,
    output logic [ADDR_W-1:0] memAddr,
    output logic              used1,
    output logic              used2,
    input  logic [3:0]        destRegStore,
    input  logic [DATA_W-1:0] destVal,
    input  logic              storeNow,
    output logic              storeDone
);

    instr_t              f;
    op_class_t           cls;
    logic [3:0]          src1;
    logic [DATA_W-1:0]   rf1, rf2, op1, op2;
    logic                byp1, byp2, hazard, accept, ready_en;
    logic [REG_CNT-1:0]  busy, busy_nxt;

    assign f    = instr;
    assign cls  = classify(f.op);
    // STORE sends rd's value out as the data to be stored
    assign src1 = (f.op == OP_STORE) ? f.rd : f.rs1;

    register_file #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .IDX_W(4)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (src1),
        .rdata1 (rf1),
        .raddr2 (f.rs2),
        .rdata2 (rf2),
        .we     (storeNow),
        .waddr  (destRegStore),
        .wdata  (destVal)
    );

    // A write-back landing this cycle satisfies a RAW dependency directly
    assign byp1 = storeNow && (destRegStore == src1);
    assign byp2 = storeNow && (destRegStore == f.rs2);
    assign op1  = byp1 ? destVal : rf1;
    assign op2  = byp2 ? destVal : rf2;

    // WAW is never bypassed: the in-flight writer must retire first
    assign hazard = instr_valid &&
                    ((cls.rd1 && busy[src1]  && !byp1) ||
                     (cls.rd2 && busy[f.rs2] && !byp2) ||
                     (cls.wr  && busy[f.rd]));

    // ready_en keeps the stage closed until the first edge after reset
    assign instr_ready = ready_en && !hazard;
    assign accept      = instr_valid && instr_ready;

    // Clear on write-back first, then set for a new writer so set wins
    always_comb begin
        busy_nxt = busy;
        if (storeNow)          busy_nxt[destRegStore] = 1'b0;
        if (accept && cls.wr)  busy_nxt[f.rd]         = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= '0;
            ready_en  <= 1'b0;
            storeDone <= 1'b0;
            opcode    <= OP_NOP;
            destReg   <= '0;
            srcVal1   <= '0;
            srcVal2   <= '0;
            memAddr   <= '0;
            used1     <= 1'b0;
            used2     <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            ready_en  <= 1'b1;
            storeDone <= storeNow;
            if (accept) begin
                opcode  <= f.op;
                destReg <= f.rd;
                memAddr <= instr[ADDR_W-1:0];
                used1   <= cls.rd1;
                used2   <= cls.rd2;
                srcVal1 <= cls.rd1 ? op1 : '0;
                srcVal2 <= cls.rd2 ? op2 : '0;
            end else begin
                // bubble: only opcode and used flags drop, the rest hold
                opcode  <= OP_NOP;
                used1   <= 1'b0;
                used2   <= 1'b0;
            end
        end
    end

endmodule
